// File: rtl/mpu_instr_scheduler.sv
// mpu_instr_scheduler: buffers host instruction bytes in a FIFO and hands them
// one at a time to the MPU control FSM. Each issue follows the same handshake:
// wait for not-busy, present the byte for one cycle, wait for busy to rise
// (acceptance), then wait for busy to fall (completion). If busy never rises,
// a timeout drops the instruction and sets a sticky error flag.
module mpu_instr_scheduler #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    host_instr,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          flush,
  input  logic          fsm_busy,
  output logic [7:0]    fsm_instr,
  output logic [AW:0]   q_count,
  output logic          q_empty,
  output logic          q_full,
  output logic [15:0]   issued_count,
  output logic          err_timeout
);

  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK, S_RUN} state_e;

  state_e                    state_q, state_d;
  logic [DEPTH-1:0][7:0]     mem_q;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]               count_q, count_d;
  logic [7:0]                fsm_instr_q, fsm_instr_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [15:0]               issued_q, issued_d;
  logic                      err_q, err_d;
  logic                      push, pop;

  assign q_count      = count_q;
  assign q_empty      = (count_q == '0);
  assign q_full       = (count_q == (AW+1)'(DEPTH));
  assign host_ready   = !q_full && !flush;
  assign fsm_instr    = fsm_instr_q;
  assign issued_count = issued_q;
  assign err_timeout  = err_q;

  // NOP bytes complete the handshake but are never stored; pops only from IDLE.
  always_comb begin
    push = host_valid && host_ready && (host_instr[3:2] != 2'b00);
    pop  = (state_q == S_IDLE) && !q_empty && !fsm_busy && !flush;
  end

  // FIFO pointer/count update; flush wins and empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Issue sequencer: next state, one-cycle instruction pulse, ack timer.
  always_comb begin
    state_d     = state_q;
    fsm_instr_d = 8'h00;
    timer_d     = timer_q;
    issued_d    = issued_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          fsm_instr_d = mem_q[rd_ptr_q];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (fsm_busy) begin
          issued_d = issued_q + 16'd1;
          state_d  = S_RUN;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          // Instruction is lost; it is deliberately not re-queued.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RUN: begin
        if (!fsm_busy) state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        fsm_instr_d = 8'h00;
      end
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fsm_instr_q <= 8'h00;
      timer_q     <= '0;
      issued_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fsm_instr_q <= fsm_instr_d;
      timer_q     <= timer_d;
      issued_q    <= issued_d;
      err_q       <= err_d;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= host_instr;
  end

endmodule

// File: tb/tb_mpu_instr_scheduler.sv
// Testbench for mpu_instr_scheduler: randomized host traffic, a behavioural
// control-FSM model driving busy, and a scoreboard of expected issue order.
module tb_mpu_instr_scheduler;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int ACK_TIMEOUT = 4;

  logic        clk = 0;
  logic        reset = 1;
  logic [7:0]  host_instr = 8'h00;
  logic        host_valid = 0;
  logic        host_ready;
  logic        flush = 0;
  logic        fsm_busy = 0;
  logic [7:0]  fsm_instr;
  logic [AW:0] q_count;
  logic        q_empty, q_full;
  logic [15:0] issued_count;
  logic        err_timeout;

  mpu_instr_scheduler #(.DEPTH(DEPTH), .AW(AW), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .host_instr(host_instr), .host_valid(host_valid),
    .host_ready(host_ready), .flush(flush), .fsm_busy(fsm_busy),
    .fsm_instr(fsm_instr), .q_count(q_count), .q_empty(q_empty), .q_full(q_full),
    .issued_count(issued_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  logic [7:0]  model_q[$];
  logic [15:0] exp_issued = 0;
  logic        exp_err = 0;
  logic [7:0]  lat = 0;
  logic        rst_seen = 0;
  logic        hold_busy = 0;
  int          busy_left = 0;
  int          blo = 1, bhi = 1;
  logic        mon_on = 0, spacing_chk = 0, track_peak = 0;
  logic [7:0]  prev_instr = 0;
  logic        prev_busy = 0;
  int          cyc = 0, last_issue = -100, peak = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gen_instr();
    logic [7:0] b;
    do b = 8'($urandom); while (b[3:2] == 2'b00 || b == 8'hDF);
    return b;
  endfunction

  // Monitor/scoreboard: checks outputs settled after the last edge, then
  // advances the queue model with the inputs that the next edge will consume.
  always @(negedge clk) begin
    if (mon_on) begin
      if (fsm_instr != 8'h00) begin
        chk("pulse_one_cycle", 32'(prev_instr), 32'h0);
        chk("issue_not_busy", 32'(prev_busy), 32'h0);
        if (model_q.size() == 0) chk("issue_unexpected", 32'(fsm_instr), 32'h0);
        else chk("issue_order", 32'(fsm_instr), 32'(model_q.pop_front()));
        if (spacing_chk) chk("issue_spacing_ge5", 32'((cyc - last_issue) >= 5), 32'h1);
        last_issue = cyc;
      end
      chk("q_count", 32'(q_count), 32'(model_q.size()));
      chk("q_empty", 32'(q_empty), 32'(model_q.size() == 0));
      chk("q_full", 32'(q_full), 32'(model_q.size() == DEPTH));
      chk("host_ready", 32'(host_ready), 32'(model_q.size() < DEPTH && !flush));
      if (track_peak && int'(q_count) > peak) peak = int'(q_count);
      lat = fsm_instr;
      rst_seen = reset;
      prev_instr = fsm_instr;
      prev_busy = fsm_busy;
      if (reset) begin
        model_q.delete();
        last_issue = -100;
      end else if (flush) begin
        model_q.delete();
      end else if (host_valid && model_q.size() < DEPTH && host_instr[3:2] != 2'b00) begin
        model_q.push_back(host_instr);
      end
      cyc++;
    end
  end

  // Control-FSM model: samples the presented instruction at the edge and
  // raises busy (a registered flag) unless it is the instruction it ignores.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rst_seen) begin
        busy_left = 0; exp_issued = 0; exp_err = 0;
      end else if (lat != 8'h00) begin
        if (lat == 8'hDF) exp_err = 1;
        else begin
          busy_left = int'($urandom_range(bhi, blo));
          exp_issued = exp_issued + 16'd1;
        end
      end else if (busy_left > 0) begin
        busy_left--;
      end
      fsm_busy = hold_busy || (busy_left > 0);
    end
  end

  task automatic push(input logic [7:0] b);
    host_valid = 1; host_instr = b;
    @(posedge clk); #1;
    host_valid = 0; host_instr = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int budget);
    int quiet = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (model_q.size() == 0 && fsm_instr == 8'h00 && !fsm_busy) quiet++;
      else quiet = 0;
      if (quiet >= ACK_TIMEOUT + 4) return;
    end
    chk("drain_timeout", 32'h1, 32'h0);
  endtask

  initial begin
    logic [15:0] base;
    logic        found;
    // Reset
    @(posedge clk); #1; mon_on = 1;
    @(posedge clk); #1; reset = 0;
    chk("rst_fsm_instr", 32'(fsm_instr), 32'h0);
    chk("rst_issued", 32'(issued_count), 32'h0);
    chk("rst_err", 32'(err_timeout), 32'h0);

    // Single ADD, busy for one cycle
    push(8'h1C);
    drain(200);
    chk("add_issued", 32'(issued_count), 32'(exp_issued));
    chk("add_issued_1", 32'(issued_count), 32'h1);
    chk("add_empty", 32'(q_empty), 32'h1);

    // NOPs interleaved with one real op
    blo = 2; bhi = 3; spacing_chk = 1;
    track_peak = 1; peak = 0;
    push(8'h30); push(8'h4E); push(8'hC0);
    drain(200);
    track_peak = 0;
    chk("nop_peak", 32'(peak), 32'h1);
    chk("nop_issued", 32'(issued_count), 32'h2);

    // Fill while a long op holds busy; 9th byte refused
    hold_busy = 1; idle(2);
    for (int i = 0; i < 9; i++) push(gen_instr());
    chk("full_q_full", 32'(q_full), 32'h1);
    chk("full_host_ready", 32'(host_ready), 32'h0);
    chk("full_q_count", 32'(q_count), 32'(DEPTH));
    hold_busy = 0;
    drain(400);
    chk("full_issued", 32'(issued_count), 32'h0A);

    // Three queued, then a stream with concurrent push/pop and pointer wrap
    hold_busy = 1; idle(2);
    for (int i = 0; i < 3; i++) push(gen_instr());
    hold_busy = 0;
    for (int i = 0; i < 24; i++) begin
      host_valid = ($urandom_range(3, 0) != 0);
      host_instr = ($urandom_range(4, 0) == 0) ? {$urandom_range(15, 0), 4'h0} | 8'($urandom_range(3, 0))
                                               : gen_instr();
      @(posedge clk); #1;
    end
    host_valid = 0; host_instr = 8'h00;
    drain(1500);
    chk("wrap_issued", 32'(issued_count), 32'(exp_issued));

    // Dropped instruction: timeout, next one still issues
    base = issued_count;
    push(8'hDF); push(8'h5A);
    drain(300);
    chk("to_err", 32'(err_timeout), 32'h1);
    chk("to_err_model", 32'(err_timeout), 32'(exp_err));
    chk("to_issued", 32'(issued_count), 32'(base + 16'd1));

    // Flush during a long RUN with a push in the same cycle
    base = issued_count;
    blo = 40; bhi = 40;
    push(8'h2D);
    idle(6);
    blo = 2; bhi = 3;
    for (int i = 0; i < 5; i++) push(gen_instr());
    chk("pre_flush_count", 32'(q_count), 32'h5);
    flush = 1; host_valid = 1; host_instr = gen_instr();
    @(posedge clk); #1;
    flush = 0; host_valid = 0; host_instr = 8'h00;
    chk("flush_count", 32'(q_count), 32'h0);
    chk("flush_empty", 32'(q_empty), 32'h1);
    drain(400);
    chk("flush_inflight_done", 32'(issued_count), 32'(base + 16'd1));
    chk("flush_err_sticky", 32'(err_timeout), 32'h1);

    // Reset while an instruction is being presented
    push(8'h17);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (fsm_instr != 8'h00) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("rst_issue_seen", 32'(found), 32'h1);
    reset = 1;
    @(posedge clk); #1;
    chk("mid_rst_fsm_instr", 32'(fsm_instr), 32'h0);
    chk("mid_rst_q_count", 32'(q_count), 32'h0);
    chk("mid_rst_q_empty", 32'(q_empty), 32'h1);
    chk("mid_rst_q_full", 32'(q_full), 32'h0);
    chk("mid_rst_host_ready", 32'(host_ready), 32'h1);
    chk("mid_rst_issued", 32'(issued_count), 32'h0);
    chk("mid_rst_err", 32'(err_timeout), 32'h0);
    @(posedge clk); #1; reset = 0;
    idle(4);
    chk("end_model_empty", 32'(model_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
